// File: rtl/program_loader.sv
// program_loader: parses header/address/payload frames from a byte stream and drives the memory load bus
// Ports: clk, rst_n (async active-low); in_valid/in_byte/in_ready stream input;
//        load, is_instruction, load_address, cpu_input load bus; cpu_hold while a frame is open;
//        done pulse at good frame end; frame_err sticky, cleared by next accepted header.
// Optional: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte per frame.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_byte,
  output logic                  in_ready,
  output logic                  load,
  output logic                  is_instruction,
  output logic [ADDR_WIDTH-1:0] load_address,
  output logic [DATA_WIDTH-1:0] cpu_input,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  frame_err
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, DONE} state_t;
  logic [DATA_WIDTH-1:0] csum;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE} state_t;
`endif
  state_t state;
  logic ty;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic acc;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ty <= 1'b0;
      cnt <= '0;
      addr <= '0;
      in_ready <= 1'b0;
      load <= 1'b0;
      is_instruction <= 1'b0;
      load_address <= '0;
      cpu_input <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      frame_err <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE: if (acc) begin
          if (in_byte[6:4] != 3'd0) frame_err <= 1'b1;
          else begin
            ty <= in_byte[7];
            cnt <= in_byte[3:0];
            frame_err <= 1'b0;
            cpu_hold <= 1'b1;
            state <= ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum <= in_byte;
`endif
          end
        end
        ADDR: if (acc) begin
          addr <= in_byte[ADDR_WIDTH-1:0];
          state <= DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum <= csum ^ in_byte;
`endif
        end
        DATA: if (acc) begin
          load <= 1'b1;
          load_address <= addr;
          cpu_input <= in_byte;
          is_instruction <= ty;
          addr <= addr + 1'b1;
          cnt <= cnt - 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum <= csum ^ in_byte;
          if (cnt == 4'd0) state <= CHK;
`else
          if (cnt == 4'd0) begin
            state <= DONE;
            done <= 1'b1;
            cpu_hold <= 1'b0;
            in_ready <= 1'b0;
          end
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: if (acc) begin
          if (in_byte == csum) begin
            state <= DONE;
            done <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state <= IDLE;
          end
          cpu_hold <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader
module tb_program_loader;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, load, is_instruction, cpu_hold, done, frame_err;
  logic [3:0] load_address;
  logic [7:0] cpu_input;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  typedef struct packed {logic ty; logic [3:0] a; logic [7:0] d; logic [31:0] c;} exp_t;
  exp_t q[$];
  logic [7:0] pl [16];

  program_loader dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .load(load), .is_instruction(is_instruction), .load_address(load_address),
    .cpu_input(cpu_input), .cpu_hold(cpu_hold), .done(done), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      check("done_hold", {31'd0, cpu_hold}, 0);
    end
    if (load) begin
      if (q.size() == 0) check("spurious_load", 1, 0);
      else begin
        e = q.pop_front();
        check("ty", {31'd0, is_instruction}, {31'd0, e.ty});
        check("addr", {28'd0, load_address}, {28'd0, e.a});
        check("data", {24'd0, cpu_input}, {24'd0, e.d});
        check("latency", cyc, e.c);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc);
    int t = 0;
    @(negedge clk);
    if (gaps) begin
      in_valid = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1;
    in_byte = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    acc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input bit gaps, input bit bad);
    int n = int'(h[3:0]) + 1, acc, d0 = done_cnt;
    logic [3:0] ad = a[3:0];
    logic [7:0] x = h ^ a;
    send_byte(h, gaps, acc);
    #1 check("hdr_hold", {31'd0, cpu_hold}, 1);
    check("hdr_err_clr", {31'd0, frame_err}, 0);
    send_byte(a, gaps, acc);
    for (int i = 0; i < n; i++) begin
      #1 check("pay_hold", {31'd0, cpu_hold}, 1);
      send_byte(pl[i], gaps, acc);
      q.push_back('{ty: h[7], a: ad, d: pl[i], c: acc});
      x ^= pl[i];
      ad++;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad ? 8'h00 : x, gaps, acc);
`endif
    idle(4);
    check("done_count", done_cnt - d0, bad ? 0 : 1);
    check("end_hold", {31'd0, cpu_hold}, 0);
    check("end_err", {31'd0, frame_err}, {31'd0, bad});
    check("q_empty", q.size(), 0);
  endtask

  initial begin
    int acc;
    in_valid = 1;
    in_byte = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_outs", {in_ready, load, is_instruction, load_address, cpu_input, cpu_hold, done, frame_err}, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 1);
    in_valid = 0;
    check("rst_idle", {load, cpu_hold, done, frame_err}, 0);
    idle(1);

    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_frame(8'h82, 8'h05, 0, 0);

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    send_frame(8'h03, 8'h0E, 0, 0);
    send_frame(8'h03, 8'h0E, 1, 0);

    send_byte(8'h10, 0, acc);
    idle(2);
    check("resv_err", {31'd0, frame_err}, 1);
    check("resv_hold", {31'd0, cpu_hold}, 0);
    check("resv_q", q.size(), 0);
    pl[0] = 8'h5A;
    send_frame(8'h00, 8'h03, 0, 0);

    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + 8'(i) * 8'd7);
    send_frame(8'h8F, 8'h00, 1, 0);

    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    send_byte(8'h03, 0, acc);
    send_byte(8'h09, 0, acc);
    for (int i = 0; i < 2; i++) begin
      send_byte(pl[i], 0, acc);
      q.push_back('{ty: 1'b0, a: 4'(9 + i), d: pl[i], c: acc});
    end
    @(negedge clk);
    #1 rst_n = 0;
    in_valid = 0;
    #1 check("mid_rst_outs", {in_ready, load, is_instruction, load_address, cpu_input, cpu_hold, done, frame_err}, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_q", q.size(), 0);
    rst_n = 1;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 1);
    pl[0] = 8'hDE; pl[1] = 8'hAD;
    send_frame(8'h81, 8'h0B, 1, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    pl[0] = 8'h10; pl[1] = 8'h20;
    send_frame(8'h81, 8'h02, 0, 0);
    send_frame(8'h81, 8'h02, 0, 1);
    send_frame(8'h81, 8'h02, 1, 0);
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
